// File: rtl/rvr32_mem_resp.sv
// rvr32_mem_resp
//   Responder end of the mem_valid/mem_ready bus. Holds 2**DEPTH_LOG2 32-bit
//   words starting at byte address BASE_ADDR and answers each request after
//   WAIT_CYCLES wait states with a one-cycle mem_ready strobe.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   mem_valid  in   1   request, held until mem_ready (dropping it while
//                       waiting aborts the transaction)
//   mem_addr   in  32   byte address (bits [1:0] ignored)
//   mem_wdata  in  32   write data
//   mem_wstrb  in   4   byte write enables, 4'b0000 = read
//   mem_rdata  out 32   read data (pre-write contents), zero unless mem_ready
//   mem_ready  out  1   one-cycle completion strobe
//   mem_err    out  1   out-of-range flag, zero unless mem_ready
module rvr32_mem_resp #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           acc_addr;
    logic [31:0]           byte_off;
    logic [31:0]           word_off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  enter_resp;
    logic                  wr_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // Abort takes priority over the final countdown step.
                if (!mem_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode. With WAIT_CYCLES=0 the read happens on the capture
    // edge itself, so decode the live bus address in IDLE and the captured
    // one otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        acc_addr = (state_q == S_IDLE) ? mem_addr : addr_q;
        byte_off = acc_addr - BASE_ADDR;
        word_off = byte_off >> 2;
        in_range = ((word_off >> DEPTH_LOG2) == '0);
        idx      = word_off[DEPTH_LOG2-1:0];
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign wr_en      = (state_q == S_RESP) && !err_q && (wstrb_q != 4'b0000);

    // ------------------------------------------------------------------
    // Request capture and registered read response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && mem_valid) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (enter_resp) begin
                rdata_q <= in_range ? mem_q[idx] : '0;
                err_q   <= !in_range;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset. The write lands on the edge that ends RESP, after
    // the read data has already been registered, so a write transaction
    // returns the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_ready = (state_q == S_RESP);
        mem_rdata = mem_ready ? rdata_q : '0;
        mem_err   = mem_ready && err_q;
    end

endmodule

// File: tb/tb_rvr32_mem_resp.sv
// tb_rvr32_mem_resp
//   Directed bench for rvr32_mem_resp. Instance A: WAIT_CYCLES=2, BASE 0,
//   64 words. Instance B: WAIT_CYCLES=0, BASE 0x1000, 16 words.
module tb_rvr32_mem_resp;

    logic clk;
    logic rst;

    logic        a_valid;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wstrb;
    logic [31:0] a_rdata;
    logic        a_ready;
    logic        a_err;

    logic        b_valid;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wstrb;
    logic [31:0] b_rdata;
    logic        b_ready;
    logic        b_err;

    int errors;
    int checks;

    rvr32_mem_resp #(
        .DEPTH_LOG2  (6),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (a_valid),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
        .mem_wstrb (a_wstrb),
        .mem_rdata (a_rdata),
        .mem_ready (a_ready),
        .mem_err   (a_err)
    );

    rvr32_mem_resp #(
        .DEPTH_LOG2  (4),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (b_valid),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .mem_wstrb (b_wstrb),
        .mem_rdata (b_rdata),
        .mem_ready (b_ready),
        .mem_err   (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One transaction on instance A. Returns cycles from request to
    // mem_ready (99 if it never came). Bus fields are scrambled once the
    // request has been sampled.
    task automatic run_a(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output int lat,
                         output logic [31:0] rdata, output logic err);
        bit done;
        done  = 1'b0;
        lat   = 99;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = addr;
        a_wdata = wdata;
        a_wstrb = wstrb;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge clk);
            a_addr  = ~addr;
            a_wdata = ~wdata;
            a_wstrb = ~wstrb;
            if (a_ready === 1'b1) begin
                done  = 1'b1;
                lat   = i;
                rdata = a_rdata;
                err   = a_err;
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 32'h10; a_wdata = '1; a_wstrb = 4'hF;
        b_valid = 1'b1; b_addr = 32'h1000; b_wdata = '1; b_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (a_ready !== 1'b0 || a_err !== 1'b0 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: ready=%b err=%b rdata=%h, required 0 0 00000000",
                     a_ready, a_err, a_rdata);
        end
        checks++;
        if (b_ready !== 1'b0 || b_err !== 1'b0 || b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: ready=%b err=%b rdata=%h, required 0 0 00000000",
                     b_ready, b_err, b_rdata);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_full_write;
        int lat;
        logic [31:0] rd;
        logic er;
        run_a(32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL write_0x10: latency=%0d err=%b, required 3 0", lat, er);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_width: ready=%b one cycle after strobe, required 0", a_ready);
        end
        run_a(32'h10, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_0x10: latency=%0d err=%b rdata=%h, required 3 0 deadbeef",
                     lat, er, rd);
        end
    endtask

    task automatic test_partial_write;
        int lat;
        logic [31:0] rd;
        logic er;
        run_a(32'h10, 32'h0000_00AA, 4'b0001, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL partial_old_data: latency=%0d err=%b rdata=%h, required 3 0 deadbeef",
                     lat, er, rd);
        end
        run_a(32'h13, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEAA || er !== 1'b0) begin
            errors++;
            $display("FAIL read_0x13: rdata=%h err=%b, required deadbeaa 0", rd, er);
        end
        run_a(32'h10, 32'h1122_3344, 4'b1010, lat, rd, er);
        run_a(32'h10, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h11AD_33AA) begin
            errors++;
            $display("FAIL lanes_1010: rdata=%h, required 11ad33aa", rd);
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        logic [31:0] rd;
        logic er;
        run_a(32'h0, 32'h0102_0304, 4'hF, lat, rd, er);
        run_a(32'hFC, 32'h5A5A_0FFC, 4'hF, lat, rd, er);
        run_a(32'h100, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_0x100: latency=%0d err=%b rdata=%h, required 3 1 00000000",
                     lat, er, rd);
        end
        run_a(32'h100, 32'hFFFF_FFFF, 4'hF, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_write_0x100: err=%b rdata=%h, required 1 00000000", er, rd);
        end
        run_a(32'hFFFF_FFFC, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_wrap: err=%b rdata=%h, required 1 00000000", er, rd);
        end
        run_a(32'h0, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0102_0304) begin
            errors++;
            $display("FAIL oor_no_alias: err=%b rdata=%h, required 0 01020304", er, rd);
        end
        run_a(32'hFC, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h5A5A_0FFC) begin
            errors++;
            $display("FAIL last_word_0xfc: err=%b rdata=%h, required 0 5a5a0ffc", er, rd);
        end
    endtask

    task automatic test_abort;
        int lat;
        int pulses;
        logic [31:0] rd;
        logic er;
        run_a(32'h20, 32'hCAFE_F00D, 4'hF, lat, rd, er);
        pulses = 0;
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 32'h20;
        a_wdata = 32'h5555_5555;
        a_wstrb = 4'hF;
        @(negedge clk);
        if (a_ready !== 1'b0) pulses++;
        @(negedge clk);
        if (a_ready !== 1'b0) pulses++;
        a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_err !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_ready: %0d cycles with ready/err set, required 0", pulses);
        end
        run_a(32'h20, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL abort_no_write: rdata=%h err=%b latency=%0d, required cafef00d 0 3",
                     rd, er, lat);
        end
    endtask

    task automatic test_reset_in_resp;
        int lat;
        logic [31:0] rd;
        logic er;
        run_a(32'h30, 32'h0BAD_C0DE, 4'hF, lat, rd, er);
        run_a(32'h30, 32'hFFFF_FFFF, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL resp_before_reset: latency=%0d, required 3", lat);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || a_err !== 1'b0 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_resp: ready=%b err=%b rdata=%h, required 0 0 00000000",
                     a_ready, a_err, a_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        run_a(32'h30, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0BAD_C0DE || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL after_reset_0x30: rdata=%h err=%b latency=%0d, required 0badc0de 0 3",
                     rd, er, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] t_addr  [8];
        logic [31:0] t_wdata [8];
        logic [3:0]  t_wstrb [8];
        logic [31:0] t_rdata [8];
        logic        t_err   [8];
        int n;
        int k;
        int bad_ready;
        n = 8;
        t_addr[0] = 32'h1000; t_wdata[0] = 32'hA0A0_A0A0; t_wstrb[0] = 4'hF; t_err[0] = 1'b0; t_rdata[0] = '0;
        t_addr[1] = 32'h1004; t_wdata[1] = 32'hB1B1_B1B1; t_wstrb[1] = 4'hF; t_err[1] = 1'b0; t_rdata[1] = '0;
        t_addr[2] = 32'h103C; t_wdata[2] = 32'hC2C2_C2C2; t_wstrb[2] = 4'hF; t_err[2] = 1'b0; t_rdata[2] = '0;
        t_addr[3] = 32'h1000; t_wdata[3] = 32'h0;         t_wstrb[3] = 4'h0; t_err[3] = 1'b0; t_rdata[3] = 32'hA0A0_A0A0;
        t_addr[4] = 32'h1004; t_wdata[4] = 32'h0;         t_wstrb[4] = 4'h0; t_err[4] = 1'b0; t_rdata[4] = 32'hB1B1_B1B1;
        t_addr[5] = 32'h103F; t_wdata[5] = 32'h0;         t_wstrb[5] = 4'h0; t_err[5] = 1'b0; t_rdata[5] = 32'hC2C2_C2C2;
        t_addr[6] = 32'h1040; t_wdata[6] = 32'h0;         t_wstrb[6] = 4'h0; t_err[6] = 1'b1; t_rdata[6] = 32'h0;
        t_addr[7] = 32'h0FFC; t_wdata[7] = 32'h0;         t_wstrb[7] = 4'h0; t_err[7] = 1'b1; t_rdata[7] = 32'h0;
        k = 0;
        bad_ready = 0;
        @(negedge clk);
        b_valid = 1'b1;
        b_addr  = t_addr[0];
        b_wdata = t_wdata[0];
        b_wstrb = t_wstrb[0];
        for (int cyc = 1; cyc <= 2 * n + 1; cyc++) begin
            @(negedge clk);
            if ((cyc % 2) == 1 && cyc <= 2 * n) begin
                if (b_ready !== 1'b1) bad_ready++;
                checks++;
                if (b_err !== t_err[k] || (t_wstrb[k] == 4'h0 && b_rdata !== t_rdata[k])) begin
                    errors++;
                    $display("FAIL b2b_txn%0d addr=%h: err=%b rdata=%h, required %b %h",
                             k, t_addr[k], b_err, b_rdata, t_err[k], t_rdata[k]);
                end
                k++;
                if (k < n) begin
                    b_addr  = t_addr[k];
                    b_wdata = t_wdata[k];
                    b_wstrb = t_wstrb[k];
                end else begin
                    b_valid = 1'b0;
                end
            end else begin
                if (b_ready !== 1'b0 || b_err !== 1'b0 || b_rdata !== 32'h0) bad_ready++;
            end
        end
        checks++;
        if (bad_ready !== 0) begin
            errors++;
            $display("FAIL b2b_ready_pattern: %0d cycles off the 1-0 strobe pattern, required 0",
                     bad_ready);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_out_of_range();
        test_abort();
        test_reset_in_resp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvr32_mem_resp.md
RVR32_MEM_RESP -- requirements
Module: rvr32_mem_resp

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 10, giving the number of 32-bit words in internal storage as 2**DEPTH_LOG2.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0, aligned to 4*2**DEPTH_LOG2.
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the wait states inserted before mem_ready.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mem_valid  input  1  initiator request, held high until mem_ready.
REQ-007 mem_addr  input  32  byte address of request.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-010 mem_rdata  output  32  read data, valid only while mem_ready=1.
REQ-011 mem_ready  output  1  one-cycle completion strobe.
REQ-012 mem_err  output  1  out-of-range flag, valid only while mem_ready=1.

Function
REQ-013 The block SHALL be the responder end of the mem_valid/mem_ready bus driven by the team's load/store arbiter, with one clock and an asynchronous active-high reset.
REQ-014 The block SHALL implement states IDLE, WAIT and RESP.
REQ-015 In IDLE with mem_valid=1 at a rising edge, the block SHALL capture mem_addr, mem_wdata and mem_wstrb, load the wait counter with WAIT_CYCLES, and enter WAIT, or RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge at which the counter reaches 0.
REQ-017 If mem_valid=0 at any edge in WAIT, the block SHALL abort: return to IDLE with no write, no mem_ready and no mem_err.
REQ-018 In RESP, mem_ready SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE unconditionally.
REQ-019 Timing: mem_valid first sampled at edge N means mem_ready is high in the cycle following edge N+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles of latency.
REQ-020 Back-to-back: a request still or newly valid in the cycle after RESP SHALL be sampled in IDLE as a new transaction, giving one idle cycle between consecutive mem_ready pulses.
REQ-021 The word index SHALL be (captured_addr - BASE_ADDR) >> 2; addr[1:0] SHALL be ignored.
REQ-022 An address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*2**DEPTH_LOG2.
REQ-023 For an in-range request, mem_rdata SHALL equal the stored word as it was before any write of the same transaction, registered, and driven only during RESP.
REQ-024 For an in-range request with mem_wstrb!=0, byte lane i SHALL be updated from mem_wdata[8i+7:8i] at the edge ending RESP when mem_wstrb[i]=1; other lanes SHALL be unchanged.
REQ-025 For an out-of-range request, the block SHALL still complete with mem_ready=1 and mem_err=1 for that cycle, mem_rdata=0, and no storage update.
REQ-026 mem_rdata and mem_err SHALL be 0 whenever mem_ready=0.
REQ-027 Changes to mem_addr, mem_wdata or mem_wstrb after capture SHALL be ignored for that transaction.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, counter=0, mem_ready=0, mem_err=0, mem_rdata=0.
REQ-029 Assertion of rst in WAIT or RESP SHALL abort the transaction with no storage write.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 The first request SHALL be sampled at the first rising edge after rst deasserts.

Verification
REQ-032 WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> mem_ready high exactly 3 cycles after valid, err=0; a subsequent read of 0x10 returns 0xDEADBEEF.
REQ-033 Partial write to 0x10 with wdata 0x000000AA, wstrb 4'b0001 -> a read of 0x13 returns 0xDEADBEAA.
REQ-034 Read of BASE_ADDR + 4*2**DEPTH_LOG2 -> mem_ready=1, mem_err=1, mem_rdata=0; storage unchanged.
REQ-035 Write to 0x20 with valid dropped after 1 cycle in WAIT -> no mem_ready; a later read of 0x20 returns the prior value.
REQ-036 WAIT_CYCLES=0 with mem_valid held high across 3 reads -> mem_ready pulses on every second cycle, each one cycle wide.
REQ-037 rst asserted during RESP of a write to 0x30 -> mem_ready drops immediately, 0x30 is unchanged, and the next request completes normally.
